// File: rtl/mult_iter_sched.sv
// mult_iter_sched: round-robin shared shift-add multiplier (req0/req1 valid-ready in, out valid-ready with id and N+M-bit product)
module mult_iter_sched #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [M-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [M-1:0] req1_b,
  output logic         req1_ready,
  output logic         out_valid,
  output logic         out_id,
  output logic [N+M-1:0] out_result,
  input  logic         out_ready
);
  localparam int W = N + M;
  localparam int CW = M > 1 ? $clog2(M) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [W-1:0] mcand, acc, acc_next;
  logic [M-1:0] mplier;
  logic [CW-1:0] cnt;
  logic id, last, gnt, accept;
  always_comb begin
    gnt = (req0_valid && req1_valid) ? !last : req1_valid;
    req0_ready = state == IDLE && req0_valid && !gnt;
    req1_ready = state == IDLE && req1_valid && gnt;
    accept = req0_ready || req1_ready;
    acc_next = acc + (mplier[0] ? mcand : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      id <= 1'b0;
      last <= 1'b1;
      out_valid <= 1'b0;
      out_id <= 1'b0;
      out_result <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        mcand <= gnt ? {{M{1'b0}}, req1_a} : {{M{1'b0}}, req0_a};
        mplier <= gnt ? req1_b : req0_b;
        acc <= '0;
        cnt <= '0;
        id <= gnt;
        last <= gnt;
        state <= RUN;
      end
    end else if (state == RUN) begin
      acc <= acc_next;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(M - 1)) begin
        out_result <= acc_next;
        out_id <= id;
        out_valid <= 1'b1;
        state <= DONE;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mult_iter_sched.sv
// tb_mult_iter_sched: vector table, directed corner sequences and randomized model check for mult_iter_sched
module tb_mult_iter_sched;
  localparam int N = 8, M = 4;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, out_ready = 0;
  logic [N-1:0] req0_a = 0, req1_a = 0;
  logic [M-1:0] req0_b = 0, req1_b = 0;
  logic req0_ready, req1_ready, out_valid, out_id;
  logic [N+M-1:0] out_result;
  int total = 0, bad = 0;

  mult_iter_sched #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_id(out_id), .out_result(out_result), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { bit p; int a; int b; int exp; } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic do_op(input bit p, input int a, input int b, output int lat);
    int w = 0;
    if (p) begin req1_valid = 1; req1_a = N'(a); req1_b = M'(b); end
    else begin req0_valid = 1; req0_a = N'(a); req0_b = M'(b); end
    #1;
    while (!(p ? req1_ready : req0_ready) && w < 20) begin
      tick;
      w++;
    end
    if (w == 20) chk("accept_timeout", 0, 1);
    tick;
    chk("ready_one_cycle", int'(p ? req1_ready : req0_ready), 0);
    req0_valid = 0;
    req1_valid = 0;
    wait_out(lat);
  endtask

  bit v0, v1, m_idle, m_ov, m_oi, m_id, m_last, g, e0, e1;
  int m_cd, m_res, m_or;

  initial begin
    int lat;
    logic [N+M-1:0] held;
    vt[0] = '{0, 13, 11, 143};
    vt[1] = '{1, 255, 15, 3825};
    vt[2] = '{0, 200, 0, 0};
    vt[3] = '{1, 1, 1, 1};
    vt[4] = '{0, 0, 15, 0};
    vt[5] = '{1, 128, 8, 1024};
    tick;
    tick;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_out_result", int'(out_result), 0);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].p, vt[i].a, vt[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, M);
      chk($sformatf("vec%0d_result", i), int'(out_result), vt[i].exp);
      chk($sformatf("vec%0d_id", i), int'(out_id), int'(vt[i].p));
      tick;
      chk($sformatf("vec%0d_out_valid_clear", i), int'(out_valid), 0);
      chk($sformatf("vec%0d_result_kept", i), int'(out_result), vt[i].exp);
    end

    rst = 1;
    tick;
    rst = 0;
    req0_valid = 1; req0_a = 3; req0_b = 5;
    req1_valid = 1; req1_a = 7; req1_b = 9;
    for (int k = 0; k < 4; k++) begin
      wait_out(lat);
      chk($sformatf("contend%0d_id", k), int'(out_id), k % 2);
      chk($sformatf("contend%0d_result", k), int'(out_result), (k % 2) ? 63 : 15);
      tick;
    end
    req0_valid = 0;
    req1_valid = 0;

    out_ready = 0;
    do_op(0, 9, 7, lat);
    req0_valid = 1; req0_a = 2; req0_b = 2;
    req1_valid = 1; req1_a = 5; req1_b = 3;
    #1;
    held = out_result;
    chk("bp_result", int'(held), 63);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_result_stable", int'(out_result), int'(held));
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
      tick;
    end
    out_ready = 1;
    tick;
    chk("bp_handshake", int'(out_valid), 0);
    chk("bp_next_ready1", int'(req1_ready), 1);
    chk("bp_next_ready0", int'(req0_ready), 0);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    wait_out(lat);
    chk("bp_next_result", int'(out_result), 15);
    chk("bp_next_id", int'(out_id), 1);
    tick;

    req0_valid = 1; req0_a = 13; req0_b = 11;
    #1;
    chk("rr_pre_ready0", int'(req0_ready), 1);
    tick;
    req0_valid = 0;
    tick;
    tick;
    rst = 1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_result", int'(out_result), 0);
    chk("midrst_out_id", int'(out_id), 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("midrst_hold_valid", int'(out_valid), 0);
    end
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("midrst_no_emit", int'(out_valid), 0);
    end
    req0_valid = 1; req0_a = 6; req0_b = 6;
    req1_valid = 1; req1_a = 6; req1_b = 6;
    #1;
    chk("post_rst_ready0", int'(req0_ready), 1);
    chk("post_rst_ready1", int'(req1_ready), 0);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    wait_out(lat);
    chk("post_rst_latency", lat, M);
    chk("post_rst_result", int'(out_result), 36);
    chk("post_rst_id", int'(out_id), 0);
    tick;

    rst = 1;
    tick;
    rst = 0;
    m_idle = 1; m_ov = 0; m_oi = 0; m_or = 0; m_last = 1; m_cd = 0; m_res = 0; m_id = 0;
    v0 = 0; v1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!v0 && $urandom_range(1, 0) == 1) begin
        v0 = 1; req0_a = N'($urandom); req0_b = M'($urandom);
      end
      if (!v1 && $urandom_range(1, 0) == 1) begin
        v1 = 1; req1_a = N'($urandom); req1_b = M'($urandom);
      end
      req0_valid = v0;
      req1_valid = v1;
      out_ready = $urandom_range(1, 0) == 1;
      #1;
      g = (v0 && v1) ? !m_last : v1;
      e0 = m_idle && v0 && !g;
      e1 = m_idle && v1 && g;
      chk("rnd_ready0", int'(req0_ready), int'(e0));
      chk("rnd_ready1", int'(req1_ready), int'(e1));
      chk("rnd_out_valid", int'(out_valid), int'(m_ov));
      chk("rnd_out_result", int'(out_result), m_or);
      chk("rnd_out_id", int'(out_id), int'(m_oi));
      if (m_idle) begin
        if (e0 || e1) begin
          m_idle = 0;
          m_cd = M;
          m_res = g ? int'(req1_a) * int'(req1_b) : int'(req0_a) * int'(req0_b);
          m_id = g;
          m_last = g;
          if (g) v1 = 0; else v0 = 0;
        end
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_ov = 1;
          m_or = m_res;
          m_oi = m_id;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 0;
        m_idle = 1;
      end
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
